// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        RELEASE,
        RUN,
        FAIL
    } state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for asynchronous level inputs
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (clears both stages)
//   d_i   in  asynchronous inputs
//   q_o   out synchronised outputs, two clk cycles behind d_i
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock supervisor with staggered per-domain reset release
//   clk          in  free-running reference clock
//   rst_n        in  asynchronous active-low reset
//   lock_i       in  raw PLL LOCK outputs (asynchronous)
//   force_i      in  synchronous pulse restarting the sequence from PLL_RESET
//   pll_resetb_o out shared PLL RESETB (active-low)
//   dom_rst_n_o  out per-domain active-low resets, bit 0 released first
//   all_ready_o  out high in RUN
//   fail_o       out high in FAIL
//   relock_o     out one-cycle pulse when lock is lost after release began
//   retries_o    out lock timeouts seen in the current sequence
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH             = 2,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int RELEASE_STAGGER    = 4,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  lock_i,
    input  logic                               force_i,
    output logic                               pll_resetb_o,
    output logic [NUM_CH-1:0]                  dom_rst_n_o,
    output logic                               all_ready_o,
    output logic                               fail_o,
    output logic                               relock_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries_o
);

    // One phase counter serves hold, stable-lock and stagger timing
    localparam int HS_MAX  = (RESET_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RESET_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (HS_MAX > RELEASE_STAGGER) ? HS_MAX : RELEASE_STAGGER;
    localparam int CW      = cnt_w(CNT_MAX);
    localparam int TW      = cnt_w(LOCK_TIMEOUT);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]       tmo_q, tmo_d, tmo_inc;
    logic [RW-1:0]       retries_q, retries_d, retries_inc;
    logic [NUM_CH-1:0]   dom_q, dom_d;
    logic                pll_q, pll_d;
    logic                ready_q, ready_d;
    logic                fail_q, fail_d;
    logic                relock_q, relock_d;
    logic [NUM_CH-1:0]   lock_s;
    logic                lock_ok;

    sync2 #(.W(NUM_CH)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (lock_i),
        .q_o   (lock_s)
    );

    assign lock_ok     = &lock_s;
    assign cnt_inc     = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
    assign tmo_inc     = (tmo_q == TW'(LOCK_TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
    assign retries_inc = (retries_q == RW'(MAX_RETRIES)) ? retries_q : retries_q + RW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        retries_d = retries_q;
        dom_d     = dom_q;
        relock_d  = 1'b0;
        if (force_i) begin
            state_d   = PLL_RESET;
            retries_d = '0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    cnt_d = lock_ok ? cnt_inc : '0;
                    tmo_d = tmo_inc;
                    // A stable lock on the timeout cycle still counts as success
                    if (lock_ok && cnt_inc == CW'(LOCK_STABLE_CYCLES)) begin
                        state_d = RELEASE;
                        dom_d   = NUM_CH'(1);
                    end else if (tmo_inc == TW'(LOCK_TIMEOUT)) begin
                        retries_d = retries_inc;
                        state_d   = (retries_inc == RW'(MAX_RETRIES)) ? FAIL : PLL_RESET;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_ok) begin
                        relock_d = 1'b1;
                        state_d  = PLL_RESET;
                    end else if (state_q == RELEASE) begin
                        // Only reachable with a single domain: everything already released
                        if (&dom_q) state_d = RUN;
                        else if (cnt_q == CW'(RELEASE_STAGGER - 1)) begin
                            dom_d = (dom_q << 1) | NUM_CH'(1);
                            cnt_d = '0;
                            if (&dom_d) state_d = RUN;
                        end else cnt_d = cnt_inc;
                    end
                end
                FAIL: ;
                default: state_d = PLL_RESET;
            endcase
        end
        if (state_d != state_q || force_i) begin
            cnt_d = '0;
            tmo_d = '0;
        end
        if (state_d == RUN) retries_d = '0;
        if (state_d != RELEASE && state_d != RUN) dom_d = '0;
        pll_d   = state_d inside {WAIT_LOCK, RELEASE, RUN};
        ready_d = state_d == RUN;
        fail_d  = state_d == FAIL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            tmo_q     <= '0;
            retries_q <= '0;
            dom_q     <= '0;
            pll_q     <= 1'b0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
            relock_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            retries_q <= retries_d;
            dom_q     <= dom_d;
            pll_q     <= pll_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
            relock_q  <= relock_d;
        end
    end

    assign pll_resetb_o = pll_q;
    assign dom_rst_n_o  = dom_q;
    assign all_ready_o  = ready_q;
    assign fail_o       = fail_q;
    assign relock_o     = relock_q;
    assign retries_o    = retries_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus randomized lock/force traffic against a reference model
module tb_pll_lock_sequencer;

    localparam int N      = 3;
    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int STAG   = 2;
    localparam int TMO    = 32;
    localparam int MAXR   = 2;
    localparam int RW     = $clog2(MAXR + 1);

    localparam int P_RESET = 0;
    localparam int P_WAIT  = 1;
    localparam int P_REL   = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAIL  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          force_i = 1'b0;
    logic [N-1:0]  lock_i = '0;
    logic          pll_resetb_o;
    logic [N-1:0]  dom_rst_n_o;
    logic          all_ready_o;
    logic          fail_o;
    logic          relock_o;
    logic [RW-1:0] retries_o;

    int checks = 0;
    int errors = 0;

    // Reference model: phase plus edges elapsed since entering it
    int m_phase;
    int m_e;
    int m_retries;
    bit m_relock;
    bit raw_q[$];
    bit ok_q[$];

    pll_lock_sequencer #(
        .NUM_CH             (N),
        .RESET_HOLD_CYCLES  (HOLD),
        .LOCK_STABLE_CYCLES (STABLE),
        .RELEASE_STAGGER    (STAG),
        .LOCK_TIMEOUT       (TMO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lock_i       (lock_i),
        .force_i      (force_i),
        .pll_resetb_o (pll_resetb_o),
        .dom_rst_n_o  (dom_rst_n_o),
        .all_ready_o  (all_ready_o),
        .fail_o       (fail_o),
        .relock_o     (relock_o),
        .retries_o    (retries_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase   = P_RESET;
        m_e       = 0;
        m_retries = 0;
        m_relock  = 1'b0;
        raw_q.delete();
        ok_q.delete();
    endtask

    task automatic model_step();
        bit ok;
        bit win;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // The sequencer sees the AND of lock_i as sampled two edges earlier
        raw_q.push_back(&lock_i);
        if (raw_q.size() > 3) void'(raw_q.pop_front());
        ok = (raw_q.size() == 3) ? raw_q[0] : 1'b0;
        ok_q.push_back(ok);
        if (ok_q.size() > STABLE) void'(ok_q.pop_front());
        win = (ok_q.size() == STABLE);
        foreach (ok_q[i]) win &= ok_q[i];
        m_relock = 1'b0;
        m_e++;
        if (force_i) begin
            m_phase = P_RESET; m_e = 0; m_retries = 0;
        end else if (m_phase == P_RESET) begin
            if (m_e == HOLD) begin m_phase = P_WAIT; m_e = 0; end
        end else if (m_phase == P_WAIT) begin
            if (m_e >= STABLE && win) begin
                m_phase = P_REL; m_e = 0;
            end else if (m_e == TMO) begin
                m_retries++;
                m_phase = (m_retries == MAXR) ? P_FAIL : P_RESET;
                m_e = 0;
            end
        end else if (m_phase == P_REL || m_phase == P_RUN) begin
            if (!ok) begin
                m_relock = 1'b1; m_phase = P_RESET; m_e = 0;
            end else if (m_phase == P_REL && m_e == ((N > 1) ? STAG * (N - 1) : 1)) begin
                m_phase = P_RUN; m_e = 0; m_retries = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_dom();
        int k;
        if (m_phase == P_RUN) return '1;
        if (m_phase != P_REL) return '0;
        k = 1 + m_e / STAG;
        if (k > N) k = N;
        return N'((1 << k) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (pll_resetb_o !== 1'b0) begin errors++; $display("FAIL reset_pll got %b exp 0", pll_resetb_o); end
        checks++; if (dom_rst_n_o !== 3'b000) begin errors++; $display("FAIL reset_dom got %b exp 000", dom_rst_n_o); end
        checks++; if (all_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", all_ready_o); end
        checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", fail_o); end
        checks++; if (relock_o !== 1'b0) begin errors++; $display("FAIL reset_relock got %b exp 0", relock_o); end
        checks++; if (retries_o !== 2'd0) begin errors++; $display("FAIL reset_retries got %0d exp 0", retries_o); end
    endtask

    task automatic test_clean_start();
        logic [N-1:0] dom_at [1:16];
        logic         pll_at [1:16];
        logic         rdy_at [1:16];
        lock_i = 3'b111;
        rst_n  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            dom_at[i] = dom_rst_n_o; pll_at[i] = pll_resetb_o; rdy_at[i] = all_ready_o;
        end
        checks++; if (pll_at[3] !== 1'b0) begin errors++; $display("FAIL clean_pll_c3 got %b exp 0", pll_at[3]); end
        checks++; if (pll_at[4] !== 1'b1) begin errors++; $display("FAIL clean_pll_c4 got %b exp 1", pll_at[4]); end
        checks++; if (dom_at[11] !== 3'b000) begin errors++; $display("FAIL clean_dom_c11 got %b exp 000", dom_at[11]); end
        checks++; if (dom_at[12] !== 3'b001) begin errors++; $display("FAIL clean_dom_c12 got %b exp 001", dom_at[12]); end
        checks++; if (dom_at[13] !== 3'b001) begin errors++; $display("FAIL clean_dom_c13 got %b exp 001", dom_at[13]); end
        checks++; if (dom_at[14] !== 3'b011) begin errors++; $display("FAIL clean_dom_c14 got %b exp 011", dom_at[14]); end
        checks++; if (dom_at[16] !== 3'b111) begin errors++; $display("FAIL clean_dom_c16 got %b exp 111", dom_at[16]); end
        checks++; if (rdy_at[15] !== 1'b0) begin errors++; $display("FAIL clean_ready_c15 got %b exp 0", rdy_at[15]); end
        checks++; if (rdy_at[16] !== 1'b1) begin errors++; $display("FAIL clean_ready_c16 got %b exp 1", rdy_at[16]); end
    endtask

    task automatic test_lock_loss();
        lock_i = 3'b011;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 2) begin
                checks++; if (relock_o !== 1'b0 || all_ready_o !== 1'b1) begin errors++; $display("FAIL loss_early got relock %b ready %b exp 0 1", relock_o, all_ready_o); end
            end
            if (i == 3) begin
                checks++; if (relock_o !== 1'b1) begin errors++; $display("FAIL loss_relock got %b exp 1", relock_o); end
                checks++; if (dom_rst_n_o !== 3'b000 || pll_resetb_o !== 1'b0) begin errors++; $display("FAIL loss_resets got dom %b pll %b exp 000 0", dom_rst_n_o, pll_resetb_o); end
                lock_i = 3'b111;
            end
            if (i == 4) begin
                checks++; if (relock_o !== 1'b0) begin errors++; $display("FAIL loss_pulse_len got %b exp 0", relock_o); end
            end
            if (i == 18) begin
                checks++; if (all_ready_o !== 1'b0) begin errors++; $display("FAIL loss_ready_c18 got %b exp 0", all_ready_o); end
            end
        end
        checks++; if (all_ready_o !== 1'b1 || dom_rst_n_o !== 3'b111) begin errors++; $display("FAIL loss_relocked got ready %b dom %b exp 1 111", all_ready_o, dom_rst_n_o); end
    endtask

    task automatic test_force_run_glitch();
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        checks++; if (pll_resetb_o !== 1'b0 || dom_rst_n_o !== 3'b000 || all_ready_o !== 1'b0) begin errors++; $display("FAIL force_run got pll %b dom %b ready %b exp 0 000 0", pll_resetb_o, dom_rst_n_o, all_ready_o); end
        checks++; if (retries_o !== 2'd0 || fail_o !== 1'b0) begin errors++; $display("FAIL force_run_flags got retries %0d fail %b exp 0 0", retries_o, fail_o); end
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (i == 8) lock_i = 3'b101;
            if (i == 9) lock_i = 3'b111;
            if (i == 12) begin
                checks++; if (dom_rst_n_o !== 3'b000) begin errors++; $display("FAIL glitch_c12 got %b exp 000", dom_rst_n_o); end
            end
            if (i == 18) begin
                checks++; if (dom_rst_n_o !== 3'b000) begin errors++; $display("FAIL glitch_c18 got %b exp 000", dom_rst_n_o); end
            end
            if (i == 19) begin
                checks++; if (dom_rst_n_o !== 3'b001) begin errors++; $display("FAIL glitch_c19 got %b exp 001", dom_rst_n_o); end
            end
        end
        checks++; if (all_ready_o !== 1'b1) begin errors++; $display("FAIL glitch_run got %b exp 1", all_ready_o); end
    endtask

    task automatic test_timeout_fail();
        lock_i = 3'b000;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i == 38) begin
                checks++; if (pll_resetb_o !== 1'b1 || retries_o !== 2'd0) begin errors++; $display("FAIL tmo_c38 got pll %b retries %0d exp 1 0", pll_resetb_o, retries_o); end
            end
            if (i == 39) begin
                checks++; if (pll_resetb_o !== 1'b0 || retries_o !== 2'd1 || fail_o !== 1'b0) begin errors++; $display("FAIL tmo_retry got pll %b retries %0d fail %b exp 0 1 0", pll_resetb_o, retries_o, fail_o); end
            end
            if (i == 42) begin
                checks++; if (pll_resetb_o !== 1'b0) begin errors++; $display("FAIL tmo_hold got %b exp 0", pll_resetb_o); end
            end
            if (i == 43) begin
                checks++; if (pll_resetb_o !== 1'b1) begin errors++; $display("FAIL tmo_rewait got %b exp 1", pll_resetb_o); end
            end
            if (i == 74) begin
                checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL tmo_c74 got %b exp 0", fail_o); end
            end
            if (i == 75) begin
                checks++; if (fail_o !== 1'b1 || retries_o !== 2'd2) begin errors++; $display("FAIL tmo_fail got fail %b retries %0d exp 1 2", fail_o, retries_o); end
                checks++; if (dom_rst_n_o !== 3'b000 || pll_resetb_o !== 1'b0) begin errors++; $display("FAIL tmo_fail_rst got dom %b pll %b exp 000 0", dom_rst_n_o, pll_resetb_o); end
            end
        end
        checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", fail_o); end
    endtask

    task automatic test_force_fail_then_async_reset();
        lock_i  = 3'b111;
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        checks++; if (fail_o !== 1'b0 || retries_o !== 2'd0 || pll_resetb_o !== 1'b0) begin errors++; $display("FAIL force_fail got fail %b retries %0d pll %b exp 0 0 0", fail_o, retries_o, pll_resetb_o); end
        for (int i = 1; i <= 14; i++) tick();
        checks++; if (dom_rst_n_o !== 3'b011) begin errors++; $display("FAIL arst_pre got %b exp 011", dom_rst_n_o); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dom_rst_n_o !== 3'b000 || pll_resetb_o !== 1'b0) begin errors++; $display("FAIL arst_now got dom %b pll %b exp 000 0", dom_rst_n_o, pll_resetb_o); end
        checks++; if (all_ready_o !== 1'b0 || fail_o !== 1'b0 || relock_o !== 1'b0 || retries_o !== 2'd0) begin errors++; $display("FAIL arst_flags got %b%b%b %0d exp 000 0", all_ready_o, fail_o, relock_o, retries_o); end
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int mode = 0;
        int seg  = 0;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                mode = $urandom_range(0, 2);
                seg  = $urandom_range(20, 120);
            end
            seg--;
            if (mode == 0) lock_i = ($urandom_range(0, 99) < 2) ? N'($urandom) : '1;
            else if (mode == 1) lock_i = '0;
            else lock_i = ($urandom_range(0, 99) < 70) ? '1 : N'($urandom);
            force_i = ($urandom_range(0, 199) == 0);
            tick();
            checks++; if (pll_resetb_o !== (m_phase inside {P_WAIT, P_REL, P_RUN})) begin errors++; $display("FAIL rnd_pll cyc %0d got %b phase %0d", c, pll_resetb_o, m_phase); end
            checks++; if (dom_rst_n_o !== exp_dom()) begin errors++; $display("FAIL rnd_dom cyc %0d got %b exp %b", c, dom_rst_n_o, exp_dom()); end
            checks++; if (all_ready_o !== (m_phase == P_RUN)) begin errors++; $display("FAIL rnd_ready cyc %0d got %b phase %0d", c, all_ready_o, m_phase); end
            checks++; if (fail_o !== (m_phase == P_FAIL)) begin errors++; $display("FAIL rnd_fail cyc %0d got %b phase %0d", c, fail_o, m_phase); end
            checks++; if (relock_o !== m_relock) begin errors++; $display("FAIL rnd_relock cyc %0d got %b exp %b", c, relock_o, m_relock); end
            checks++; if (retries_o !== RW'(m_retries)) begin errors++; $display("FAIL rnd_retries cyc %0d got %0d exp %0d", c, retries_o, m_retries); end
        end
        force_i = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_start();
        test_lock_loss();
        test_force_run_glitch();
        test_timeout_fail();
        test_force_fail_then_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
